// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter: IDLE -> ACCESS -> GRANT -> RELEASE.
// Latency: at least 4 cycles from the arbitration edge to the next arbitration; ACCESS stretches until bus_ready.
// Backpressure: bus_ready stalls ACCESS; non-winning requests stay pending. Optional ARB_TIMEOUT_EN bounds the wait.
module bus_arbiter #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  rw_in,
  input  logic [39:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [3:0]  grant,
  output logic [7:0]  rdata,
  output logic        bus_valid,
  output logic        bus_rw,
  output logic [9:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ready,
  input  logic [7:0]  bus_rdata,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {IDLE, ACCESS, GRANT, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last, last_nxt;
  logic [1:0]  win, win_nxt;
  logic [3:0]  grant_nxt;
  logic [7:0]  rdata_nxt;
  logic        bus_valid_nxt;
  logic        bus_rw_nxt;
  logic [9:0]  bus_addr_nxt;
  logic [7:0]  bus_wdata_nxt;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic          timeout_nxt;
`endif

  // Round-robin pick: first active request starting just after the last winner.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    win_nxt       = win;
    grant_nxt     = 4'b0000;
    rdata_nxt     = rdata;
    bus_valid_nxt = bus_valid;
    bus_rw_nxt    = bus_rw;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
`ifdef ARB_TIMEOUT_EN
    tcnt_nxt      = tcnt;
    timeout_nxt   = timeout_flag;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          win_nxt       = pick;
          bus_rw_nxt    = rw_in[pick];
          bus_addr_nxt  = addr_in[pick*10 +: 10];
          bus_wdata_nxt = wdata_in[pick*8 +: 8];
          bus_valid_nxt = 1'b1;
          state_nxt     = ACCESS;
`ifdef ARB_TIMEOUT_EN
          tcnt_nxt      = '0;
`endif
        end
      end
      ACCESS: begin
        if (bus_ready) begin
          rdata_nxt     = bus_rdata;
          bus_valid_nxt = 1'b0;
          grant_nxt     = 4'b0001 << win;
          state_nxt     = GRANT;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tcnt == CW'(TIMEOUT_CYC - 1)) begin
          rdata_nxt     = 8'hFF;
          bus_valid_nxt = 1'b0;
          grant_nxt     = 4'b0001 << win;
          timeout_nxt   = 1'b1;
          state_nxt     = GRANT;
        end else begin
          tcnt_nxt      = tcnt + 1'b1;
        end
`endif
      end
      GRANT: begin
        last_nxt  = win;
        state_nxt = RELEASE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 2'd3;
      win       <= 2'd0;
      grant     <= 4'b0000;
      rdata     <= 8'h00;
      bus_valid <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= 10'h000;
      bus_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      win       <= win_nxt;
      grant     <= grant_nxt;
      rdata     <= rdata_nxt;
      bus_valid <= bus_valid_nxt;
      bus_rw    <= bus_rw_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // ACCESS-cycle counter and sticky timeout indicator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      tcnt         <= tcnt_nxt;
      timeout_flag <= timeout_nxt;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected transactions queued at stimulus time,
// popped when the grant pulse appears; a behavioural slave answers bus accesses.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  rw_in = '0;
  logic [39:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [3:0]  grant;
  logic [7:0]  rdata;
  logic        bus_valid;
  logic        bus_rw;
  logic [9:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ready = 1'b0;
  logic [7:0]  bus_rdata = '0;
  logic        timeout_flag;

  bus_arbiter #(.TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset(reset), .req(req), .rw_in(rw_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .grant(grant), .rdata(rdata), .bus_valid(bus_valid),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       rw;
    logic [9:0] addr;
    logic [7:0] wd;
    logic [7:0] rd;
    int         vcyc;
  } exp_t;

  exp_t q[$];
  int   gq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   vcnt = 0;
  int   rdy_dly = 0;
  int   wcnt = 0;
  bit   force_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int i, input logic rw, input logic [9:0] a, input logic [7:0] wd);
    rw_in[i]            = rw;
    addr_in[10*i +: 10] = a;
    wdata_in[8*i +: 8]  = wd;
  endtask

  // Slave returns addr[7:0]^0xA0 so rdata can be predicted from the address.
  task automatic push_exp(input int w, input int vcyc, input bit tmo);
    exp_t e;
    e.g    = 4'(1 << w);
    e.rw   = rw_in[w];
    e.addr = addr_in[10*w +: 10];
    e.wd   = wdata_in[8*w +: 8];
    e.rd   = tmo ? 8'hFF : (e.addr[7:0] ^ 8'hA0);
    e.vcyc = vcyc;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_valid && n < budget);
    if (!bus_valid) chk("valid_timeout", bus_valid, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    req       = '0;
    force_rdy = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    reset = 1'b0;
  endtask

  // Behavioural downstream slave with programmable ready delay.
  always @(negedge clk) begin
    if (force_rdy) begin
      bus_ready = 1'b1;
      bus_rdata = 8'hEE;
    end else if (bus_valid && !reset) begin
      if (wcnt == rdy_dly) begin
        bus_ready = 1'b1;
        bus_rdata = bus_addr[7:0] ^ 8'hA0;
      end else begin
        bus_ready = 1'b0;
      end
      wcnt++;
    end else begin
      bus_ready = 1'b0;
      wcnt      = 0;
    end
  end

  // Scoreboard monitor: bus fields while valid, grant/rdata on the grant pulse.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      vcnt = 0;
    end else begin
      if (bus_valid) begin
        if (q.size() == 0) begin
          chk("unexp_valid", bus_valid, 0);
        end else begin
          vcnt++;
          chk("bus_addr", bus_addr, q[0].addr);
          chk("bus_rw", bus_rw, q[0].rw);
          chk("bus_wdata", bus_wdata, q[0].wd);
        end
      end
      if (grant != 4'b0000) begin
        gq.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexp_grant", grant, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("grant", grant, e.g);
          chk("rdata", rdata, e.rd);
          chk("valid_cycles", vcnt, e.vcyc);
`ifndef ARB_TIMEOUT_EN
          chk("timeout_flag_zero", timeout_flag, 0);
`endif
        end
        vcnt = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++)
      set_port(i, 1'b0, 10'(10'h010 * (i + 1) + i), 8'(8'h11 * (i + 1)));

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rw", bus_rw, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_timeout", timeout_flag, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single read from requester 0, ready one cycle late
    set_port(0, 1'b0, 10'h005, 8'h00);
    rdy_dly = 1;
    req = 4'b0001;
    push_exp(0, 2, 1'b0);
    wait_drain(40);
    req = 4'b0000;

    // bus_ready outside ACCESS is ignored
    repeat (3) @(negedge clk);
    force_rdy = 1'b1;
    repeat (5) @(negedge clk);
    chk("ign_ready_valid", bus_valid, 0);
    chk("ign_ready_grant", grant, 0);
    chk("ign_ready_rdata", rdata, 8'hA5);
    force_rdy = 1'b0;

    // All four requesting, zero-wait slave: strict rotation every 4 cycles
    apply_reset();
    rdy_dly = 0;
    gq.delete();
    req = 4'b1111;
    push_exp(0, 1, 1'b0);
    push_exp(1, 1, 1'b0);
    push_exp(2, 1, 1'b0);
    push_exp(3, 1, 1'b0);
    push_exp(0, 1, 1'b0);
    wait_drain(80);
    req = 4'b0000;
    if (gq.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("grant_spacing", gq[i+1] - gq[i], 4);
    end else begin
      chk("grant_count", gq.size(), 5);
    end

    // GPIO write from requester 2, fields held through wait states
    apply_reset();
    set_port(2, 1'b1, 10'h203, 8'h3C);
    rdy_dly = 3;
    req = 4'b0100;
    push_exp(2, 4, 1'b0);
    wait_drain(40);
    req = 4'b0000;
    set_port(2, 1'b0, 10'h032, 8'h33);

    // Reset mid-ACCESS aborts without grant; first edge after release arbitrates
    apply_reset();
    rdy_dly = 100;
    req = 4'b0001;
    push_exp(0, 1, 1'b0);
    wait_valid(20);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", bus_valid, 0);
    chk("abort_grant", grant, 0);
    q.delete();
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rdy_dly = 0;
    req = 4'b0001;
    push_exp(0, 1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_arb_valid", bus_valid, 1);
    wait_drain(40);
    req = 4'b0000;

    // Winner drops req during ACCESS; still granted, pending requester next
    apply_reset();
    rdy_dly = 3;
    req = 4'b0011;
    push_exp(0, 4, 1'b0);
    push_exp(1, 4, 1'b0);
    wait_valid(20);
    req = 4'b0010;
    wait_drain(60);
    req = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: timeout after 15 ACCESS cycles
    apply_reset();
    rdy_dly = 1000;
    req = 4'b0001;
    push_exp(0, 15, 1'b1);
    wait_drain(60);
    req = 4'b0000;
    chk("timeout_set", timeout_flag, 1);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", timeout_flag, 1);
    apply_reset();
    chk("timeout_cleared", timeout_flag, 0);
`endif

    repeat (5) @(negedge clk);
    chk("end_idle_grant", grant, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
